// File: rtl/l2_cache_pkg.sv
// Shared types for the L2 N-way cache controller.
// State encoding and pmem address-mux select codes.
package l2_cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    FLUSH_CHK,
    FLUSH_WB
  } state_t;

  localparam logic [1:0] PMEM_CPU    = 2'd0;
  localparam logic [1:0] PMEM_VICTIM = 2'd1;
  localparam logic [1:0] PMEM_FLUSH  = 2'd2;

endpackage

// File: rtl/l2_way_prio_enc.sv
// Lowest-index priority encoder for a per-way hit vector.
// Ports: i_vec (WAYS) -> o_idx (WAY_W), o_onehot (WAYS), o_any.
module l2_way_prio_enc #(
  parameter int WAYS = 4,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]  i_vec,
  output logic [WAY_W-1:0] o_idx,
  output logic [WAYS-1:0]  o_onehot,
  output logic             o_any
);

  always_comb begin
    o_idx = '0;
    // Walk downward so the lowest set bit wins.
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = WAY_W'(i);
    end
  end

  // Isolate the lowest set bit.
  assign o_onehot = i_vec & (~i_vec + WAYS'(1));
  assign o_any    = |i_vec;

endmodule

// File: rtl/l2_cache_control_nway.sv
// Control FSM for the L2 N-way write-back cache with a whole-cache flush walk.
// Ports: CPU req (mem_read/mem_write/mem_resp), array lookup inputs
// (hit_vec/lru_way/victim_dirty), per-way array write strobes
// (tag/valid/dirty_load, way_wr_sel, dirty_in, lru_load, fill_sel),
// flush indexing (set_sel/flush_set/flush_way), pmem handshake
// (pmem_read/pmem_write/pmem_addr_sel/pmem_resp), flush_req/flush_done.
// Macro L2_PERF_CNT_EN adds hit_cnt/miss_cnt/wb_cnt outputs.
module l2_cache_control_nway
  import l2_cache_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int SETS  = 8,
  parameter int CNT_W = 32,
  localparam int WAY_W = $clog2(WAYS),
  localparam int SET_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic [WAYS-1:0]  hit_vec,
  input  logic [WAY_W-1:0] lru_way,
  input  logic             victim_dirty,
  output logic             array_read,
  output logic [WAYS-1:0]  tag_load,
  output logic [WAYS-1:0]  valid_load,
  output logic [WAYS-1:0]  dirty_load,
  output logic             dirty_in,
  output logic             lru_load,
  output logic [WAYS-1:0]  way_wr_sel,
  output logic             fill_sel,
  output logic             set_sel,
  output logic [SET_W-1:0] flush_set,
  output logic [WAY_W-1:0] flush_way,
  output logic [1:0]       pmem_addr_sel,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  input  logic             flush_req,
  output logic             flush_done
`ifdef L2_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt
`endif
);

  state_t r_state;
  state_t w_next;

  logic [SET_W-1:0] r_flush_set;
  logic [WAY_W-1:0] r_flush_way;

  logic             w_req;
  logic             w_hit;
  logic [WAYS-1:0]  w_hit_oh;
  logic [WAY_W-1:0] w_unused_hit_idx;
  logic [WAYS-1:0]  w_lru_oh;
  logic [WAYS-1:0]  w_flush_oh;
  logic             w_adv;
  logic             w_last;
  logic             w_idle;

  l2_way_prio_enc #(
    .WAYS(WAYS)
  ) u_hit_enc (
    .i_vec   (hit_vec),
    .o_idx   (w_unused_hit_idx),
    .o_onehot(w_hit_oh),
    .o_any   (w_hit)
  );

  assign w_req      = mem_read | mem_write;
  assign w_idle     = (r_state == IDLE);
  assign w_lru_oh   = WAYS'(1) << lru_way;
  assign w_flush_oh = WAYS'(1) << r_flush_way;

  assign w_last = (r_flush_set == SET_W'(SETS - 1)) &&
                  (r_flush_way == WAY_W'(WAYS - 1));

  // One walk step completes: clean entry seen, or dirty entry written back.
  assign w_adv = ((r_state == FLUSH_CHK) && !victim_dirty) ||
                 ((r_state == FLUSH_WB) && pmem_resp);

  assign flush_set = r_flush_set;
  assign flush_way = r_flush_way;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush_set <= '0;
      r_flush_way <= '0;
    end else if (w_adv) begin
      if (w_last) begin
        r_flush_set <= '0;
        r_flush_way <= '0;
      end else begin
        r_flush_way <= r_flush_way + 1'b1;
        if (r_flush_way == WAY_W'(WAYS - 1)) begin
          r_flush_set <= r_flush_set + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_req && !w_hit) begin
          w_next = victim_dirty ? WRITEBACK : ALLOCATE;
        end else if (!w_req && flush_req) begin
          w_next = FLUSH_CHK;
        end
      end
      WRITEBACK: begin
        if (pmem_resp) w_next = ALLOCATE;
      end
      ALLOCATE: begin
        if (pmem_resp) w_next = IDLE;
      end
      FLUSH_CHK: begin
        if (victim_dirty) w_next = FLUSH_WB;
        else if (w_last)  w_next = IDLE;
      end
      FLUSH_WB: begin
        if (pmem_resp) w_next = w_last ? IDLE : FLUSH_CHK;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_resp      = 1'b0;
    array_read    = 1'b0;
    tag_load      = '0;
    valid_load    = '0;
    dirty_load    = '0;
    dirty_in      = 1'b0;
    lru_load      = 1'b0;
    way_wr_sel    = '0;
    fill_sel      = 1'b0;
    set_sel       = 1'b0;
    pmem_addr_sel = PMEM_CPU;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    flush_done    = 1'b0;
    unique case (r_state)
      IDLE: begin
        array_read = w_req;
        if (w_req && w_hit) begin
          mem_resp = 1'b1;
          lru_load = 1'b1;
          if (mem_write) begin
            way_wr_sel = w_hit_oh;
            dirty_load = w_hit_oh;
            dirty_in   = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = PMEM_VICTIM;
      end
      ALLOCATE: begin
        pmem_read  = 1'b1;
        array_read = 1'b1;
        if (pmem_resp) begin
          fill_sel   = 1'b1;
          way_wr_sel = w_lru_oh;
          tag_load   = w_lru_oh;
          valid_load = w_lru_oh;
          dirty_load = w_lru_oh;
        end
      end
      FLUSH_CHK: begin
        set_sel    = 1'b1;
        array_read = 1'b1;
        flush_done = w_adv && w_last;
      end
      FLUSH_WB: begin
        set_sel       = 1'b1;
        pmem_write    = 1'b1;
        pmem_addr_sel = PMEM_FLUSH;
        if (pmem_resp) dirty_load = w_flush_oh;
        flush_done = w_adv && w_last;
      end
      default: begin
        mem_resp = 1'b0;
      end
    endcase
  end

`ifdef L2_PERF_CNT_EN
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;
  logic [CNT_W-1:0] r_wb_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if (w_idle && w_req && w_hit) begin
        r_hit_cnt <= r_hit_cnt + 1'b1;
      end
      if (w_idle && w_req && !w_hit) begin
        r_miss_cnt <= r_miss_cnt + 1'b1;
      end
      if (pmem_resp &&
          (r_state == WRITEBACK || r_state == FLUSH_WB)) begin
        r_wb_cnt <= r_wb_cnt + 1'b1;
      end
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
  assign wb_cnt   = r_wb_cnt;
`endif

endmodule

// File: tb/tb_l2_cache_control_nway.sv
// Self-checking bench for l2_cache_control_nway.
// DUT a: WAYS=4/SETS=8 CPU paths; DUT b: WAYS=2/SETS=2 flush walks.
module tb_l2_cache_control_nway;
  import l2_cache_pkg::*;

  logic clk, rst;
  int n_chk = 0;
  int n_fail = 0;
  int exp_hit = 0, exp_miss = 0, exp_wb = 0;

  logic       a_mem_read, a_mem_write, a_vd, a_pmem_resp, a_flush_req;
  logic [3:0] a_hit_vec;
  logic [1:0] a_lru_way;
  logic       a_mem_resp, a_array_read, a_dirty_in, a_lru_load;
  logic       a_fill_sel, a_set_sel, a_pmem_read, a_pmem_write;
  logic       a_flush_done;
  logic [3:0] a_tag_load, a_valid_load, a_dirty_load, a_way_wr_sel;
  logic [2:0] a_flush_set;
  logic [1:0] a_flush_way, a_addr_sel;

  logic       b_mem_read, b_mem_write, b_vd, b_pmem_resp, b_flush_req;
  logic [1:0] b_hit_vec;
  logic [0:0] b_lru_way;
  logic       b_mem_resp, b_array_read, b_dirty_in, b_lru_load;
  logic       b_fill_sel, b_set_sel, b_pmem_read, b_pmem_write;
  logic       b_flush_done;
  logic [1:0] b_tag_load, b_valid_load, b_dirty_load, b_way_wr_sel;
  logic [0:0] b_flush_set, b_flush_way;
  logic [1:0] b_addr_sel;
  logic       b_dirty [2][2];

`ifdef L2_PERF_CNT_EN
  logic [31:0] a_hit_cnt, a_miss_cnt, a_wb_cnt;
  logic [31:0] b_hit_cnt, b_miss_cnt, b_wb_cnt;
`endif

  // Flush-side dirty bits come from a small array model of the cache.
  assign b_vd = b_set_sel ? b_dirty[b_flush_set][b_flush_way] : 1'b0;

  l2_cache_control_nway #(.WAYS(4), .SETS(8)) dut (
    .clk(clk), .rst(rst),
    .mem_read(a_mem_read), .mem_write(a_mem_write),
    .mem_resp(a_mem_resp), .hit_vec(a_hit_vec),
    .lru_way(a_lru_way), .victim_dirty(a_vd),
    .array_read(a_array_read), .tag_load(a_tag_load),
    .valid_load(a_valid_load), .dirty_load(a_dirty_load),
    .dirty_in(a_dirty_in), .lru_load(a_lru_load),
    .way_wr_sel(a_way_wr_sel), .fill_sel(a_fill_sel),
    .set_sel(a_set_sel), .flush_set(a_flush_set),
    .flush_way(a_flush_way), .pmem_addr_sel(a_addr_sel),
    .pmem_read(a_pmem_read), .pmem_write(a_pmem_write),
    .pmem_resp(a_pmem_resp), .flush_req(a_flush_req),
    .flush_done(a_flush_done)
`ifdef L2_PERF_CNT_EN
    , .hit_cnt(a_hit_cnt), .miss_cnt(a_miss_cnt), .wb_cnt(a_wb_cnt)
`endif
  );

  l2_cache_control_nway #(.WAYS(2), .SETS(2)) dut2 (
    .clk(clk), .rst(rst),
    .mem_read(b_mem_read), .mem_write(b_mem_write),
    .mem_resp(b_mem_resp), .hit_vec(b_hit_vec),
    .lru_way(b_lru_way), .victim_dirty(b_vd),
    .array_read(b_array_read), .tag_load(b_tag_load),
    .valid_load(b_valid_load), .dirty_load(b_dirty_load),
    .dirty_in(b_dirty_in), .lru_load(b_lru_load),
    .way_wr_sel(b_way_wr_sel), .fill_sel(b_fill_sel),
    .set_sel(b_set_sel), .flush_set(b_flush_set),
    .flush_way(b_flush_way), .pmem_addr_sel(b_addr_sel),
    .pmem_read(b_pmem_read), .pmem_write(b_pmem_write),
    .pmem_resp(b_pmem_resp), .flush_req(b_flush_req),
    .flush_done(b_flush_done)
`ifdef L2_PERF_CNT_EN
    , .hit_cnt(b_hit_cnt), .miss_cnt(b_miss_cnt), .wb_cnt(b_wb_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] low_bit(input logic [3:0] v);
    int x;
    x = int'(v);
    return 4'(x & -x);
  endfunction

  // Wait for the pmem request, hold it lat cycles, then raise pmem_resp.
  // Returns at negedge of the response cycle.
  task automatic a_phase(input logic exp_wr, input logic [1:0] exp_sel,
                         input int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!(a_pmem_read | a_pmem_write) && n < 20) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk("pm_wait", n < 20, 1'b1);
    chk("pm_excl", a_pmem_read & a_pmem_write, 1'b0);
    chk("pm_write", a_pmem_write, exp_wr);
    chk("pm_read", a_pmem_read, !exp_wr);
    chk("pm_sel", a_addr_sel, exp_sel);
    chk("pm_noresp", a_mem_resp, 1'b0);
    for (int i = 1; i < lat; i++) begin
      tick();
      @(negedge clk);
      chk("pm_hold", {a_pmem_read, a_pmem_write}, {!exp_wr, exp_wr});
    end
    tick();
    a_pmem_resp = 1'b1;
    @(negedge clk);
  endtask

  task automatic a_hit(input logic wr, input logic [3:0] hv);
    logic [3:0] oh;
    oh = low_bit(hv);
    a_mem_read = !wr;
    a_mem_write = wr;
    a_hit_vec = hv;
    @(negedge clk);
    chk("hit_resp", a_mem_resp, 1'b1);
    chk("hit_lru", a_lru_load, 1'b1);
    chk("hit_dl", a_dirty_load, wr ? oh : 4'b0);
    chk("hit_wsel", a_way_wr_sel, wr ? oh : 4'b0);
    chk("hit_pm", {a_pmem_read, a_pmem_write}, 2'b00);
    exp_hit++;
    tick();
    a_mem_read = 1'b0;
    a_mem_write = 1'b0;
    a_hit_vec = '0;
  endtask

  task automatic a_miss(input logic wr, input logic dirty,
                        input logic [1:0] lru, input int lat);
    logic [3:0] oh;
    oh = 4'b0001 << lru;
    a_mem_read = !wr;
    a_mem_write = wr;
    a_hit_vec = '0;
    a_vd = dirty;
    a_lru_way = lru;
    a_pmem_resp = 1'b0;
    @(negedge clk);
    chk("miss_resp", a_mem_resp, 1'b0);
    chk("miss_ar", a_array_read, 1'b1);
    exp_miss++;
    tick();
    if (dirty) begin
      a_phase(1'b1, PMEM_VICTIM, lat);
      chk("wb_noload", {a_tag_load, a_dirty_load}, 8'h00);
      exp_wb++;
      tick();
      a_pmem_resp = 1'b0;
    end
    a_phase(1'b0, PMEM_CPU, lat);
    chk("fill_sel", a_fill_sel, 1'b1);
    chk("fill_tag", a_tag_load, oh);
    chk("fill_valid", a_valid_load, oh);
    chk("fill_dirty", a_dirty_load, oh);
    chk("fill_wsel", a_way_wr_sel, oh);
    chk("fill_din", a_dirty_in, 1'b0);
    chk("fill_ar", a_array_read, 1'b1);
    chk("fill_noresp", a_mem_resp, 1'b0);
    tick();
    a_pmem_resp = 1'b0;
    a_hit_vec = oh;
    @(negedge clk);
    chk("relook_resp", a_mem_resp, 1'b1);
    chk("relook_dl", a_dirty_load, wr ? oh : 4'b0);
    chk("relook_pm", {a_pmem_read, a_pmem_write}, 2'b00);
    exp_hit++;
    tick();
    a_mem_read = 1'b0;
    a_mem_write = 1'b0;
    a_hit_vec = '0;
    a_vd = 1'b0;
  endtask

  // Full flush on DUT b; expectations come from walking the dirty map.
  task automatic b_flush(input bit rnd_lat);
    int exp_q[$];
    int vis_q[$];
    int wb_q[$];
    int idx, wcnt, lat, dones;
    bit fin;
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 2; w++)
        if (b_dirty[s][w]) exp_q.push_back(s * 2 + w);
    wcnt = 0;
    dones = 0;
    fin = 0;
    lat = rnd_lat ? int'($urandom_range(1, 3)) : 3;
    b_flush_req = 1'b1;
    for (int c = 0; c < 200 && !fin; c++) begin
      tick();
      if (b_set_sel) b_flush_req = 1'b0;
      b_pmem_resp = 1'b0;
      if (b_pmem_write) begin
        wcnt++;
        if (wcnt >= lat) begin
          b_pmem_resp = 1'b1;
          wcnt = 0;
          lat = rnd_lat ? int'($urandom_range(1, 3)) : 3;
        end
      end
      @(negedge clk);
      idx = int'(b_flush_set) * 2 + int'(b_flush_way);
      if (b_set_sel && !b_pmem_write) vis_q.push_back(idx);
      if (b_pmem_write) chk("fl_sel", b_addr_sel, PMEM_FLUSH);
      if (b_pmem_write && b_pmem_resp) begin
        wb_q.push_back(idx);
        chk("fl_dl", b_dirty_load, 2'b01 << b_flush_way);
        chk("fl_din", b_dirty_in, 1'b0);
        b_dirty[b_flush_set][b_flush_way] = 1'b0;
      end
      if (b_flush_done) begin
        dones++;
        fin = 1;
      end
    end
    chk("fl_done", fin, 1'b1);
    tick();
    b_pmem_resp = 1'b0;
    @(negedge clk);
    chk("fl_idle", b_set_sel, 1'b0);
    chk("fl_once", b_flush_done, 1'b0);
    chk("fl_set0", b_flush_set, 1'b0);
    chk("fl_way0", b_flush_way, 1'b0);
    chk("fl_nvis", vis_q.size(), 4);
    for (int i = 0; i < vis_q.size(); i++) chk("fl_vis", vis_q[i], i);
    chk("fl_nwb", wb_q.size(), exp_q.size());
    for (int i = 0; i < wb_q.size() && i < exp_q.size(); i++)
      chk("fl_wb", wb_q[i], exp_q[i]);
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 2; w++) chk("fl_clean", b_dirty[s][w], 1'b0);
    tick();
  endtask

  typedef struct {
    logic       rd;
    logic       wr;
    logic [3:0] hv;
    logic       pr;
    logic       fr;
    logic       e_resp;
    logic       e_lru;
    logic [3:0] e_wsel;
    logic       e_din;
    logic       e_ar;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n, bad;
    bit done;
    vecs[0] = '{1'b1, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1000, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 4'b0110, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b1};

    rst = 1'b1;
    {a_mem_read, a_mem_write, a_vd, a_pmem_resp, a_flush_req} = '0;
    a_hit_vec = '0;
    a_lru_way = '0;
    {b_mem_read, b_mem_write, b_pmem_resp, b_flush_req} = '0;
    b_hit_vec = '0;
    b_lru_way = '0;
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < 2; w++) b_dirty[s][w] = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp", a_mem_resp, 1'b0);
    chk("rst_pmem", {a_pmem_read, a_pmem_write}, 2'b00);
    chk("rst_setsel", a_set_sel, 1'b0);
    chk("rst_addrsel", a_addr_sel, 2'd0);
    chk("rst_fset", a_flush_set, 3'd0);
    chk("rst_fway", a_flush_way, 2'd0);
    chk("rst_done", a_flush_done, 1'b0);
`ifdef L2_PERF_CNT_EN
    chk("rst_cnt", {a_hit_cnt, a_miss_cnt, a_wb_cnt}, '0);
`endif
    tick();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      a_mem_read = vecs[i].rd;
      a_mem_write = vecs[i].wr;
      a_hit_vec = vecs[i].hv;
      a_pmem_resp = vecs[i].pr;
      a_flush_req = vecs[i].fr;
      @(negedge clk);
      chk("tbl_resp", a_mem_resp, vecs[i].e_resp);
      chk("tbl_lru", a_lru_load, vecs[i].e_lru);
      chk("tbl_wsel", a_way_wr_sel, vecs[i].e_wsel);
      chk("tbl_dl", a_dirty_load, vecs[i].e_wsel);
      chk("tbl_din", a_dirty_in, vecs[i].e_din);
      chk("tbl_ar", a_array_read, vecs[i].e_ar);
      chk("tbl_quiet", {a_set_sel, a_pmem_read, a_pmem_write,
                        a_fill_sel, a_tag_load, a_valid_load}, '0);
      if (vecs[i].e_resp) exp_hit++;
      tick();
    end
    {a_mem_read, a_mem_write, a_pmem_resp, a_flush_req} = '0;
    a_hit_vec = '0;
    tick();

    a_miss(1'b0, 1'b1, 2'd2, 3);
    a_miss(1'b1, 1'b0, 2'd1, 1);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1)
        a_hit(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)));
      else
        a_miss(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
    end

    a_mem_read = 1'b1;
    a_hit_vec = 4'b0010;
    a_flush_req = 1'b1;
    a_vd = 1'b0;
    @(negedge clk);
    chk("pri_resp", a_mem_resp, 1'b1);
    chk("pri_nosel", a_set_sel, 1'b0);
    exp_hit++;
    tick();
    a_mem_read = 1'b0;
    a_hit_vec = '0;
    @(negedge clk);
    chk("pri_idle", a_set_sel, 1'b0);
    tick();
    a_flush_req = 1'b0;
    a_mem_read = 1'b1;
    a_hit_vec = 4'b1111;
    n = 0;
    bad = 0;
    done = 0;
    @(negedge clk);
    for (int c = 0; c < 100 && !done; c++) begin
      if (a_set_sel) n++;
      if (a_mem_resp || a_lru_load) bad++;
      if (a_flush_done) done = 1;
      else begin
        tick();
        @(negedge clk);
      end
    end
    chk("af_done", done, 1'b1);
    chk("af_visits", n, 32);
    chk("af_blocked", bad, 0);
    tick();
    @(negedge clk);
    chk("af_served", a_mem_resp, 1'b1);
    chk("af_fset", a_flush_set, 3'd0);
    chk("af_fway", a_flush_way, 2'd0);
    exp_hit++;
    tick();
    a_mem_read = 1'b0;
    a_hit_vec = '0;

`ifdef L2_PERF_CNT_EN
    @(negedge clk);
    chk("cnt_hit", a_hit_cnt, exp_hit);
    chk("cnt_miss", a_miss_cnt, exp_miss);
    chk("cnt_wb", a_wb_cnt, exp_wb);
    tick();
`endif

    a_mem_read = 1'b1;
    a_hit_vec = '0;
    a_vd = 1'b1;
    tick();
    @(negedge clk);
    chk("ar_inwb", a_pmem_write, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("ar_wdrop", a_pmem_write, 1'b0);
    chk("ar_rdrop", a_pmem_read, 1'b0);
`ifdef L2_PERF_CNT_EN
    chk("ar_cnt", {a_hit_cnt, a_miss_cnt, a_wb_cnt}, '0);
`endif
    a_mem_read = 1'b0;
    a_vd = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("ar_idle", {a_pmem_read, a_pmem_write, a_mem_resp}, 3'b000);
    tick();

    b_dirty[1][0] = 1'b1;
    b_flush(1'b0);
    for (int r = 0; r < 5; r++) begin
      for (int s = 0; s < 2; s++)
        for (int w = 0; w < 2; w++)
          b_dirty[s][w] = 1'($urandom_range(0, 1));
      b_flush(1'b1);
    end

    b_dirty[1][1] = 1'b1;
    b_flush_req = 1'b1;
    tick();
    b_flush_req = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("ab_pre", b_flush_set, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("ab_set", b_flush_set, 1'b0);
    chk("ab_way", b_flush_way, 1'b0);
    chk("ab_sel", b_set_sel, 1'b0);
    chk("ab_done", b_flush_done, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ab_quiet", {b_set_sel, b_flush_done, b_pmem_write}, 3'b000);
      tick();
    end
    b_dirty[1][1] = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
